// File: rtl/mul_share_arb_if.sv
// rtl/mul_share_arb_if.sv - requester, multiplier and response bundle for the shared multiplier arbiter
interface mul_share_arb_if #(
   parameter int NREQ = 4,
   parameter int DW   = 9,
   parameter int OW   = 18
);
   logic                 en;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*DW-1:0]   req_d1;
   logic [NREQ*DW-1:0]   req_d2;
   logic [DW-1:0]        mul_d1;
   logic [DW-1:0]        mul_d2;
   logic [OW-1:0]        mul_do;
   logic [NREQ-1:0]      rsp_valid;
   logic [OW-1:0]        rsp_data;

   // Requesters plus the multiplier, seen from outside the arbiter
   modport master (
      output en, req_valid, req_d1, req_d2, mul_do,
      input  req_ready, mul_d1, mul_d2, rsp_valid, rsp_data
   );

   // The arbiter itself
   modport slave (
      input  en, req_valid, req_d1, req_d2, mul_do,
      output req_ready, mul_d1, mul_d2, rsp_valid, rsp_data
   );
endinterface

// File: rtl/mul_share_arb.sv
// rtl/mul_share_arb.sv - round-robin sharing of one pipelined signed multiplier; MUL_SHARE_ARB_PERF_EN adds perf counters
module mul_share_arb #(
   parameter int NREQ = 4,
   parameter int DW   = 9,
   parameter int OW   = 18,
   parameter int LAT  = 2
) (
   input  logic          clk,
   input  logic          rst,
   mul_share_arb_if.slave bus
`ifdef MUL_SHARE_ARB_PERF_EN
   ,
   output logic [31:0]   perf_ops,
   output logic [31:0]   perf_stall
`endif
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [DW-1:0]             mul_d1_q, mul_d1_d;
   logic [DW-1:0]             mul_d2_q, mul_d2_d;
   logic [LAT-1:0]            tag_v_q, tag_v_d;
   logic [LAT-1:0][IW-1:0]    tag_idx_q, tag_idx_d;
   logic [NREQ-1:0]           rsp_valid_q, rsp_valid_d;

   logic                      gnt_found;
   logic [IW-1:0]             gnt_idx;
   logic                      xfer;

   // Round-robin search starting at rr_ptr; first valid requester wins
   always_comb begin
      logic [IW-1:0] cand;
      cand      = '0;
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(rr_ptr_q) + k) % NREQ);
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   // Grant, pointer advance, operand capture and tag/response pipeline
   always_comb begin
      xfer          = gnt_found & bus.en & ~rst;
      bus.req_ready = xfer ? (NREQ'(1) << gnt_idx) : '0;

      rr_ptr_d = rr_ptr_q;
      mul_d1_d = mul_d1_q;
      mul_d2_d = mul_d2_q;
      if (xfer) begin
         rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
         mul_d1_d = bus.req_d1[gnt_idx*DW +: DW];
         mul_d2_d = bus.req_d2[gnt_idx*DW +: DW];
      end

      tag_v_d      = '0;
      tag_idx_d    = '0;
      tag_v_d[0]   = xfer;
      tag_idx_d[0] = gnt_idx;
      for (int i = 1; i < LAT; i++) begin
         tag_v_d[i]   = tag_v_q[i-1];
         tag_idx_d[i] = tag_idx_q[i-1];
      end

      rsp_valid_d = tag_v_q[LAT-1] ? (NREQ'(1) << tag_idx_q[LAT-1]) : '0;
   end

   // State registers; reset discards every in-flight tag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         mul_d1_q    <= '0;
         mul_d2_q    <= '0;
         tag_v_q     <= '0;
         tag_idx_q   <= '0;
         rsp_valid_q <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         mul_d1_q    <= mul_d1_d;
         mul_d2_q    <= mul_d2_d;
         tag_v_q     <= tag_v_d;
         tag_idx_q   <= tag_idx_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign bus.mul_d1    = mul_d1_q;
   assign bus.mul_d2    = mul_d2_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = bus.mul_do;

`ifdef MUL_SHARE_ARB_PERF_EN
   logic [31:0] perf_ops_q, perf_ops_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Accepted transfers and cycles where someone waited without a transfer
   always_comb begin
      perf_ops_d   = perf_ops_q + 32'(xfer);
      perf_stall_d = perf_stall_q + 32'((|bus.req_valid) & ~xfer);
   end

   // Free-running wrapping counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_ops_q   <= '0;
         perf_stall_q <= '0;
      end else begin
         perf_ops_q   <= perf_ops_d;
         perf_stall_q <= perf_stall_d;
      end
   end

   assign perf_ops   = perf_ops_q;
   assign perf_stall = perf_stall_q;
`endif
endmodule

// File: tb/tb_mul_share_arb.sv
// tb/tb_mul_share_arb.sv - scoreboard bench for mul_share_arb with a behavioural pipelined multiplier
module tb_mul_share_arb;
   localparam int NREQ = 4;
   localparam int DW   = 9;
   localparam int OW   = 18;
   localparam int LAT  = 2;

   typedef struct {
      logic [NREQ-1:0] v;
      logic [OW-1:0]   p;
      int              c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   logic signed [DW-1:0] op_a [NREQ];
   logic signed [DW-1:0] op_b [NREQ];
   logic [OW-1:0]        prod4 [NREQ];
   logic signed [OW-1:0] mpipe [LAT];

   mul_share_arb_if #(.NREQ(NREQ), .DW(DW), .OW(OW)) bus ();

`ifdef MUL_SHARE_ARB_PERF_EN
   logic [31:0] perf_ops;
   logic [31:0] perf_stall;
   mul_share_arb #(.NREQ(NREQ), .DW(DW), .OW(OW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus), .perf_ops(perf_ops), .perf_stall(perf_stall));
`else
   mul_share_arb #(.NREQ(NREQ), .DW(DW), .OW(OW), .LAT(LAT)) dut (
      .clk(clk), .rst(rst), .bus(bus));
`endif

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural multiplier: LAT register stages after the operand registers
   always @(posedge clk) begin
      mpipe[0] <= $signed(bus.mul_d1) * $signed(bus.mul_d2);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
   end
   assign bus.mul_do = mpipe[LAT-1];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: an expected response must appear exactly in its cycle, nothing else may
   always @(negedge clk) begin
      if (sb.size() != 0 && sb[0].c <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(e.v));
         if (bus.rsp_valid != '0) chk("rsp_data", 32'(bus.rsp_data), 32'(e.p));
      end else if (bus.rsp_valid != '0) begin
         chk("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
      end
   end

   task automatic step(input logic e, input logic [NREQ-1:0] v, input logic [NREQ-1:0] exp_rdy,
                       input logic [OW-1:0] exp_p, input logic push, input string nm);
      bus.en        = e;
      bus.req_valid = v;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_d1[i*DW +: DW] = op_a[i];
         bus.req_d2[i*DW +: DW] = op_b[i];
      end
      #1;
      chk(nm, 32'(bus.req_ready), 32'(exp_rdy));
      if (push && exp_rdy != '0) sb.push_back('{exp_rdy, exp_p, cyc + 1 + LAT});
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, '0, '0, '0, 1'b0, "idle_rdy");
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         op_a[i] = '0;
         op_b[i] = '0;
      end
      bus.en        = 1'b1;
      bus.req_valid = '1;
      bus.req_d1    = '0;
      bus.req_d2    = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("reset_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_mul_d1", 32'(bus.mul_d1), 32'd0);
      chk("reset_mul_d2", 32'(bus.mul_d2), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      bus.req_valid = '0;
      rst = 1'b0;

      // Single op on requester 0
      op_a[0] = 9'sd2; op_b[0] = 9'sd6;
      step(1'b1, 4'b0001, 4'b0001, 18'd12, 1'b1, "single_gnt");
      idle(3);

      // Signed back to back on requester 0 (pointer now 1, wraps round to 0)
      op_a[0] = 9'sd100;  op_b[0] = 9'sd100;
      step(1'b1, 4'b0001, 4'b0001, 18'h02710, 1'b1, "btb_gnt0");
      op_a[0] = -9'sd10;  op_b[0] = 9'sd10;
      step(1'b1, 4'b0001, 4'b0001, 18'h3FF9C, 1'b1, "btb_gnt1");
      op_a[0] = -9'sd100; op_b[0] = -9'sd100;
      step(1'b1, 4'b0001, 4'b0001, 18'h02710, 1'b1, "btb_gnt2");
      idle(3);

      // Requester 3 alone: search 1,2,3 -> 3, pointer returns to 0
      op_a[3] = 9'sd3; op_b[3] = -9'sd4;
      step(1'b1, 4'b1000, 4'b1000, 18'h3FFF4, 1'b1, "align_gnt3");

      // All four requesting: grants rotate 0,1,2,3 twice
      op_a[0] = 9'sd1;  op_b[0] = 9'sd1;  prod4[0] = 18'd1;
      op_a[1] = 9'sd2;  op_b[1] = -9'sd3; prod4[1] = 18'h3FFFA;
      op_a[2] = -9'sd4; op_b[2] = -9'sd5; prod4[2] = 18'd20;
      op_a[3] = 9'sd7;  op_b[3] = 9'sd8;  prod4[3] = 18'd56;
      for (int j = 0; j < 8; j++)
         step(1'b1, 4'b1111, 4'b0001 << (j % 4), prod4[j % 4], 1'b1, "rr_all_gnt");
      idle(3);

      // Fairness wrap with extreme operands
      op_a[2] = -9'sd256; op_b[2] = -9'sd256;
      op_a[0] = 9'sd255;  op_b[0] = -9'sd256;
      step(1'b1, 4'b0100, 4'b0100, 18'h10000, 1'b1, "wrap_gnt2");
      step(1'b1, 4'b0101, 4'b0001, 18'h30100, 1'b1, "wrap_gnt0");
      step(1'b1, 4'b0100, 4'b0100, 18'h10000, 1'b1, "wrap_gnt2b");

      // en low with one op in flight; it must still drain
      op_a[3] = 9'sd5; op_b[3] = 9'sd5;
      step(1'b1, 4'b1000, 4'b1000, 18'd25, 1'b1, "en_inflight_gnt3");
      op_a[1] = 9'sd6; op_b[1] = -9'sd7;
      for (int j = 0; j < 5; j++) step(1'b0, 4'b0010, 4'b0000, '0, 1'b0, "en_off_rdy");
      step(1'b1, 4'b0010, 4'b0010, 18'h3FFD6, 1'b1, "en_on_gnt1");
      idle(4);

      // Reset with two ops in flight; their responses must vanish
      op_a[2] = 9'sd1; op_b[2] = 9'sd2;
      op_a[0] = 9'sd3; op_b[0] = 9'sd3;
      step(1'b1, 4'b0100, 4'b0100, '0, 1'b0, "pre_rst_gnt2");
      step(1'b1, 4'b0001, 4'b0001, '0, 1'b0, "pre_rst_gnt0");
      rst = 1'b1;
      bus.req_valid = 4'b1111;
      #1;
      chk("midrst_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_mul_d1", 32'(bus.mul_d1), 32'd0);
      chk("midrst_mul_d2", 32'(bus.mul_d2), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      bus.req_valid = '0;
      idle(4);
      op_a[0] = -9'sd1; op_b[0] = -9'sd1;
      op_a[1] = -9'sd2; op_b[1] = 9'sd3;
      step(1'b1, 4'b0011, 4'b0001, 18'd1, 1'b1, "post_rst_gnt0");
      step(1'b1, 4'b0010, 4'b0010, 18'h3FFFA, 1'b1, "post_rst_gnt1");
      idle(5);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
